// File: rtl/lif_pkg.sv
// Shared types, default constants and helper functions for the LIF neuron array.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_NUM_NEURONS = 4;
  localparam int DEF_LEAK_SHIFT  = 3;
  localparam int DEF_BASE_THR    = 50;
  localparam int DEF_THR_INC     = 16;
  localparam int DEF_THR_MAX     = 240;
  localparam int DEF_REFRACTORY  = 2;

  // Ceiling log2, but never below one bit so zero-width vectors cannot appear.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

  // Unsigned add clamped to the largest value representable in w bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational single-neuron step: leak, integrate with saturation, fire,
// refractory countdown and adaptive threshold with cap and decay.
module lif_update
  import lif_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int BASE_THR   = DEF_BASE_THR,
  parameter int THR_INC    = DEF_THR_INC,
  parameter int THR_MAX    = DEF_THR_MAX,
  parameter int REFRACTORY = DEF_REFRACTORY,
  parameter int REF_W      = clog2_min1(REFRACTORY + 1)
) (
  input  logic [WIDTH-1:0] v_i,
  input  logic [WIDTH-1:0] thr_i,
  input  logic [REF_W-1:0] ref_i,
  input  logic [WIDTH-1:0] cur_i,
  output logic [WIDTH-1:0] v_o,
  output logic [WIDTH-1:0] thr_o,
  output logic [REF_W-1:0] ref_o,
  output logic             spike_o
);

  localparam logic [WIDTH:0]   THR_INC_W = (WIDTH + 1)'(THR_INC);
  localparam logic [WIDTH:0]   THR_MAX_W = (WIDTH + 1)'(THR_MAX);
  localparam logic [WIDTH-1:0] BASE_W    = WIDTH'(BASE_THR);
  localparam bit               THR_FIXED = (BASE_THR >= THR_MAX);

  logic [WIDTH-1:0] v_leak;
  logic [WIDTH-1:0] v_new;
  logic [WIDTH:0]   thr_up;
  logic [WIDTH-1:0] thr_capped;

  always_comb begin
    v_leak     = v_i - (v_i >> LEAK_SHIFT);
    v_new      = WIDTH'(sat_add(32'(v_leak), 32'(cur_i), WIDTH));
    thr_up     = {1'b0, thr_i} + THR_INC_W;
    thr_capped = (thr_up > THR_MAX_W) ? THR_MAX_W[WIDTH-1:0] : thr_up[WIDTH-1:0];

    v_o     = '0;
    ref_o   = '0;
    spike_o = 1'b0;
    thr_o   = thr_i;

    if (ref_i != '0) begin
      ref_o = ref_i - REF_W'(1);
    end else if (v_new >= thr_i) begin
      spike_o = 1'b1;
      ref_o   = REF_W'(REFRACTORY);
      thr_o   = thr_capped;
    end else begin
      v_o = v_new;
    end

    // Decay applies on every silent step, refractory steps included.
    if (!spike_o && (thr_i > BASE_W)) begin
      thr_o = thr_i - WIDTH'(1);
    end else begin
      thr_o = thr_o;
    end

    if (THR_FIXED) begin
      thr_o = BASE_W;
    end else begin
      thr_o = thr_o;
    end
  end

endmodule

// File: rtl/lif_array.sv
// Time-multiplexed array of LIF neurons sharing one lif_update datapath,
// with a valid/ready step request and a valid/ready spike result.
module lif_array
  import lif_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int LEAK_SHIFT  = DEF_LEAK_SHIFT,
  parameter int BASE_THR    = DEF_BASE_THR,
  parameter int THR_INC     = DEF_THR_INC,
  parameter int THR_MAX     = DEF_THR_MAX,
  parameter int REFRACTORY  = DEF_REFRACTORY,
  localparam int IDX_W      = clog2_min1(NUM_NEURONS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         step_valid,
  output logic                         step_ready,
  input  logic [NUM_NEURONS*WIDTH-1:0] currents,
  output logic                         spike_valid,
  input  logic                         spike_ready,
  output logic [NUM_NEURONS-1:0]       spikes,
  input  logic [IDX_W-1:0]             mon_idx,
  output logic [WIDTH-1:0]             mon_v,
  output logic [WIDTH-1:0]             mon_thr
);

  localparam int               REF_W    = clog2_min1(REFRACTORY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_e                       state_q;
  logic [IDX_W-1:0]             idx_q;
  logic [NUM_NEURONS*WIDTH-1:0] cur_q;
  logic [WIDTH-1:0]             v_q   [NUM_NEURONS];
  logic [WIDTH-1:0]             thr_q [NUM_NEURONS];
  logic [REF_W-1:0]             ref_q [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]       acc_q;
  logic [NUM_NEURONS-1:0]       spikes_q;
  logic                         step_ready_q;
  logic                         spike_valid_q;
  logic [WIDTH-1:0]             mon_v_q;
  logic [WIDTH-1:0]             mon_thr_q;

  logic [WIDTH-1:0]       v_sel, thr_sel, cur_sel;
  logic [REF_W-1:0]       ref_sel;
  logic [WIDTH-1:0]       v_d, thr_d, mon_v_d, mon_thr_d;
  logic [REF_W-1:0]       ref_d;
  logic                   spike_d;
  logic [NUM_NEURONS-1:0] acc_d;

  always_comb begin
    v_sel   = v_q[idx_q];
    thr_sel = thr_q[idx_q];
    ref_sel = ref_q[idx_q];
    cur_sel = cur_q[idx_q*WIDTH +: WIDTH];
    acc_d   = acc_q;
    acc_d[idx_q] = spike_d;
    if (int'(mon_idx) < NUM_NEURONS) begin
      mon_v_d   = v_q[mon_idx];
      mon_thr_d = thr_q[mon_idx];
    end else begin
      mon_v_d   = '0;
      mon_thr_d = '0;
    end
  end

  lif_update #(
    .WIDTH      (WIDTH),
    .LEAK_SHIFT (LEAK_SHIFT),
    .BASE_THR   (BASE_THR),
    .THR_INC    (THR_INC),
    .THR_MAX    (THR_MAX),
    .REFRACTORY (REFRACTORY),
    .REF_W      (REF_W)
  ) u_update (
    .v_i     (v_sel),
    .thr_i   (thr_sel),
    .ref_i   (ref_sel),
    .cur_i   (cur_sel),
    .v_o     (v_d),
    .thr_o   (thr_d),
    .ref_o   (ref_d),
    .spike_o (spike_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cur_q         <= '0;
      acc_q         <= '0;
      spikes_q      <= '0;
      step_ready_q  <= 1'b1;
      spike_valid_q <= 1'b0;
      mon_v_q       <= '0;
      mon_thr_q     <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_q[i]   <= '0;
        thr_q[i] <= WIDTH'(BASE_THR);
        ref_q[i] <= '0;
      end
    end else begin
      // Monitor reads stored state, so a neuron shows its new value the cycle after its write.
      mon_v_q   <= mon_v_d;
      mon_thr_q <= mon_thr_d;
      case (state_q)
        IDLE: begin
          if (step_valid) begin
            cur_q        <= currents;
            idx_q        <= '0;
            acc_q        <= '0;
            step_ready_q <= 1'b0;
            state_q      <= UPDATE;
          end
        end
        UPDATE: begin
          v_q[idx_q]   <= v_d;
          thr_q[idx_q] <= thr_d;
          ref_q[idx_q] <= ref_d;
          acc_q        <= acc_d;
          if (idx_q == LAST_IDX) begin
            spikes_q      <= acc_d;
            spike_valid_q <= 1'b1;
            state_q       <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (spike_ready) begin
            spike_valid_q <= 1'b0;
            step_ready_q  <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: begin
          spike_valid_q <= 1'b0;
          step_ready_q  <= 1'b1;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign step_ready  = step_ready_q;
  assign spike_valid = spike_valid_q;
  assign spikes      = spikes_q;
  assign mon_v       = mon_v_q;
  assign mon_thr     = mon_thr_q;

endmodule

// File: tb/tb_lif_array.sv
// Self-checking bench for lif_array: constant tables for the documented scenarios
// plus random steps compared against an integer reference model.
module tb_lif_array;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int LEAK  = 3;
  localparam int BASE  = 50;
  localparam int INC   = 16;
  localparam int TMAX  = 240;
  localparam int REFR  = 2;
  localparam int VMAX  = 255;

  logic           clk;
  logic           reset;
  logic           step_valid;
  logic           step_ready;
  logic [N*W-1:0] currents;
  logic           spike_valid;
  logic           spike_ready;
  logic [N-1:0]   spikes;
  logic [1:0]     mon_idx;
  logic [W-1:0]   mon_v;
  logic [W-1:0]   mon_thr;

  int errors = 0;
  int checks = 0;

  int mv[N], mthr[N], mref[N];
  int mspk;
  int stim_cur[N];

  typedef struct {
    int cur0;
    int spk;
    int v0;
    int thr0;
  } vec_t;
  vec_t integ_tbl[6];

  lif_array dut (
    .clk         (clk),
    .reset       (reset),
    .step_valid  (step_valid),
    .step_ready  (step_ready),
    .currents    (currents),
    .spike_valid (spike_valid),
    .spike_ready (spike_ready),
    .spikes      (spikes),
    .mon_idx     (mon_idx),
    .mon_v       (mon_v),
    .mon_thr     (mon_thr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; mthr[i] = BASE; mref[i] = 0;
    end
  endtask

  // One time-step of every neuron, straight from the arithmetic rules.
  task automatic model_step();
    mspk = 0;
    for (int i = 0; i < N; i++) begin
      int vn;
      bit s;
      s = 0;
      if (mref[i] > 0) begin
        mref[i]--;
        mv[i] = 0;
      end else begin
        vn = mv[i] - mv[i] / (2 ** LEAK) + stim_cur[i];
        if (vn > VMAX) vn = VMAX;
        if (vn >= mthr[i]) begin
          s = 1;
          mv[i] = 0;
          mref[i] = REFR;
          mthr[i] = (mthr[i] + INC > TMAX) ? TMAX : mthr[i] + INC;
        end else begin
          mv[i] = vn;
        end
      end
      if (!s && mthr[i] > BASE) mthr[i]--;
      if (s) mspk |= (1 << i);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic start_and_wait();
    int cnt;
    @(negedge clk);
    chk("step_ready_idle", step_ready, 1);
    for (int i = 0; i < N; i++) currents[i*W +: W] = 8'(stim_cur[i]);
    step_valid = 1'b1;
    @(posedge clk);
    model_step();
    @(negedge clk);
    step_valid = 1'b0;
    cnt = 0;
    while (!spike_valid && cnt < 20) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    // Handshake edge plus N update edges; first valid in cycle N+1 counting the handshake cycle as 0.
    chk("latency", cnt, N);
    chk("spikes", spikes, mspk);
  endtask

  task automatic ack();
    spike_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    spike_ready = 1'b0;
    chk("spike_valid_clr", spike_valid, 0);
    chk("step_ready_ret", step_ready, 1);
  endtask

  task automatic do_step();
    start_and_wait();
    ack();
  endtask

  task automatic read_mon(input int i, output int rv, output int rthr);
    mon_idx = 2'(i);
    @(posedge clk);
    @(negedge clk);
    rv = int'(mon_v);
    rthr = int'(mon_thr);
  endtask

  task automatic check_all();
    int rv, rthr;
    for (int i = 0; i < N; i++) begin
      read_mon(i, rv, rthr);
      chk($sformatf("mon_v[%0d]", i), rv, mv[i]);
      chk($sformatf("mon_thr[%0d]", i), rthr, mthr[i]);
    end
  endtask

  task automatic set_cur(input int c0, input int c1, input int c2, input int c3);
    stim_cur[0] = c0; stim_cur[1] = c1; stim_cur[2] = c2; stim_cur[3] = c3;
  endtask

  task automatic run_integ_table();
    int rv, rthr;
    for (int s = 0; s < 6; s++) begin
      set_cur(integ_tbl[s].cur0, 0, 0, 0);
      do_step();
      chk($sformatf("integ_spk[%0d]", s), mspk, integ_tbl[s].spk);
      read_mon(0, rv, rthr);
      chk($sformatf("integ_v0[%0d]", s), rv, integ_tbl[s].v0);
      chk($sformatf("integ_thr0[%0d]", s), rthr, integ_tbl[s].thr0);
    end
  endtask

  initial begin
    int rv, rthr, k, bp_spk, bp_v;

    integ_tbl[0] = '{20, 0, 20, 50};
    integ_tbl[1] = '{20, 0, 38, 50};
    integ_tbl[2] = '{20, 1, 0, 66};
    integ_tbl[3] = '{20, 0, 0, 65};
    integ_tbl[4] = '{20, 0, 0, 64};
    integ_tbl[5] = '{20, 0, 20, 63};

    reset = 1'b1; step_valid = 1'b0; spike_ready = 1'b0;
    currents = '0; mon_idx = 2'd0;
    set_cur(0, 0, 0, 0);

    // Reset values, checked while reset is still held.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_step_ready", step_ready, 1);
    chk("rst_spike_valid", spike_valid, 0);
    chk("rst_spikes", spikes, 0);
    chk("rst_mon_v", mon_v, 0);
    chk("rst_mon_thr", mon_thr, 0);
    reset = 1'b0;
    model_reset();
    check_all();

    run_integ_table();

    // Threshold cap and saturation on neuron 2.
    do_reset();
    k = 0;
    while (mthr[2] != TMAX && k < 60) begin
      set_cur(0, 0, 255, 0);
      do_step();
      chk($sformatf("cap_spk_period[%0d]", k), spikes[2], (k % 3 == 0) ? 1 : 0);
      k++;
    end
    check_all();
    read_mon(2, rv, rthr);
    chk("cap_thr2", rthr, TMAX);
    set_cur(0, 0, 200, 0);
    do_step();
    read_mon(2, rv, rthr);
    chk("cap_ref1_v2", rv, 0);
    chk("cap_ref1_thr2", rthr, 239);
    do_step();
    read_mon(2, rv, rthr);
    chk("cap_ref2_thr2", rthr, 238);
    do_step();
    read_mon(2, rv, rthr);
    chk("satA_spk", spikes[2], 0);
    chk("satA_v2", rv, 200);
    chk("satA_thr2", rthr, 237);
    do_step();
    read_mon(2, rv, rthr);
    chk("satB_spk", spikes[2], 1);
    chk("satB_v2", rv, 0);
    chk("satB_thr2", rthr, TMAX);
    check_all();

    // Threshold decay back to rest.
    do_reset();
    for (int s = 0; s < 3; s++) begin
      set_cur(20, 0, 0, 0);
      do_step();
    end
    read_mon(0, rv, rthr);
    chk("decay_start_thr0", rthr, 66);
    for (int s = 1; s <= 21; s++) begin
      set_cur(0, 0, 0, 0);
      do_step();
      read_mon(0, rv, rthr);
      chk($sformatf("decay_thr0[%0d]", s), rthr, (66 - s < BASE) ? BASE : 66 - s);
    end

    // Backpressure in DONE with step_valid toggling.
    set_cur(20, 60, 255, 7);
    mon_idx = 2'd2;
    start_and_wait();
    bp_spk = int'(spikes);
    @(posedge clk);
    @(negedge clk);
    bp_v = int'(mon_v);
    for (int c = 0; c < 5; c++) begin
      step_valid = (c % 2 == 0) ? 1'b1 : 1'b0;
      currents = 32'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp_valid[%0d]", c), spike_valid, 1);
      chk($sformatf("bp_spikes[%0d]", c), spikes, bp_spk);
      chk($sformatf("bp_ready[%0d]", c), step_ready, 0);
      chk($sformatf("bp_mon_v[%0d]", c), mon_v, bp_v);
    end
    step_valid = 1'b0;
    ack();
    check_all();

    // Reset while the update index is 2.
    set_cur(20, 20, 20, 20);
    @(negedge clk);
    for (int i = 0; i < N; i++) currents[i*W +: W] = 8'(stim_cur[i]);
    step_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    step_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("midrst_step_ready", step_ready, 1);
    chk("midrst_spike_valid", spike_valid, 0);
    chk("midrst_spikes", spikes, 0);
    check_all();
    run_integ_table();

    // Random steps against the reference model.
    for (int s = 0; s < 40; s++) begin
      for (int i = 0; i < N; i++)
        stim_cur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40);
      do_step();
      check_all();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
